// File: rtl/dmem_wbuf.sv
// Data-memory stage: single-cycle local word RAM plus a write-through FIFO
// that mirrors every store to an external valid/ready bus without stalling the core.
module dmem_wbuf #(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        MemWriteM,
  input  logic [31:0]                 ALUResultM,
  input  logic [31:0]                 WriteDataM,
  output logic [31:0]                 ReadDataM,
  output logic                        bus_valid,
  input  logic                        bus_ready,
  output logic [31:0]                 bus_addr,
  output logic [31:0]                 bus_wdata,
  output logic [$clog2(FIFO_DEPTH):0] wbuf_count,
  output logic                        wbuf_full,
  output logic                        wbuf_overflow,
  output logic                        misaligned
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;

  logic [31:0]      fifoAddr [FIFO_DEPTH];
  logic [31:0]      fifoData [FIFO_DEPTH];
  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic [CNT_W-1:0] count;
  logic             pop;
  logic             accept;
  logic             drop;

  // Upper address bits are ignored, so the RAM aliases every 2^ADDR_W words.
  assign idx       = ALUResultM[ADDR_W+1:2];
  assign ReadDataM = mem[idx];

  always_ff @(posedge clk) begin
    if (MemWriteM) mem[idx] <= WriteDataM;
  end

  assign bus_valid  = (count != '0);
  assign bus_addr   = fifoAddr[headPtr];
  assign bus_wdata  = fifoData[headPtr];
  assign wbuf_count = count;
  assign wbuf_full  = (count == FULL_CNT);

  // A pop in the same cycle frees the slot, so a store at full is only lost without one.
  assign pop    = bus_valid & bus_ready;
  assign accept = MemWriteM & (~wbuf_full | pop);
  assign drop   = MemWriteM & wbuf_full & ~pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      headPtr       <= '0;
      tailPtr       <= '0;
      count         <= '0;
      wbuf_overflow <= 1'b0;
      misaligned    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifoAddr[i] <= '0;
        fifoData[i] <= '0;
      end
    end else begin
      misaligned <= MemWriteM & (|ALUResultM[1:0]);
      if (accept) begin
        fifoAddr[tailPtr] <= {ALUResultM[31:2], 2'b00};
        fifoData[tailPtr] <= WriteDataM;
        tailPtr           <= tailPtr + PTR_W'(1);
      end
      if (pop) headPtr <= headPtr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop) wbuf_overflow <= 1'b1;
    end
  end

endmodule

// File: doc/dmem_wbuf.md
Name: dmem_wbuf

Overview:
- Data-memory stage sitting directly downstream of the RV32I core's memory stage.
- Consumes MemWriteM, ALUResultM and WriteDataM, and returns ReadDataM in the same cycle from a local word RAM.
- Mirrors every store into a write-through FIFO that drains to an external bus over a valid/ready handshake (DMA or debug mirror).
- The core cannot stall, so FIFO loss is flagged, never back-pressured.

Parameters:
- ADDR_W, 10, word-address bits; local RAM depth = 2^ADDR_W words of 32 bits.
- FIFO_DEPTH, 4, write-buffer entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- MemWriteM  input  1  store strobe from the core's M stage.
- ALUResultM  input  32  byte address for load/store.
- WriteDataM  input  32  store data.
- ReadDataM  output  32  load data, combinational.
- bus_valid  output  1  FIFO head entry valid.
- bus_ready  input  1  external sink accepts the head entry.
- bus_addr  output  32  head entry address, word aligned.
- bus_wdata  output  32  head entry data.
- wbuf_count  output  $clog2(FIFO_DEPTH)+1  occupied entries.
- wbuf_full  output  1  wbuf_count == FIFO_DEPTH.
- wbuf_overflow  output  1  sticky: a store was dropped from the FIFO.
- misaligned  output  1  registered one-cycle pulse: the last store had ALUResultM[1:0] != 0.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values:
  - wbuf_count=0, head/tail pointers=0, bus_valid=0, wbuf_overflow=0, misaligned=0.
  - FIFO storage is cleared, so bus_addr=0 and bus_wdata=0.
  - RAM contents are not reset and are retained across reset.
- Reset mid-operation: all pending FIFO entries are discarded; an entry being handshaken in that cycle counts as not transferred.
- Indexing:
  - idx = ALUResultM[ADDR_W+1:2].
  - Bits [1:0] are ignored for access.
  - Upper bits above ADDR_W+1 are ignored, so the RAM aliases.
- Load path:
  - ReadDataM = mem[idx], combinational, zero latency.
  - A same-cycle store to idx is not visible until the next cycle (read-before-write).
- Store: on a rising edge with MemWriteM=1:
  - mem[idx] <= WriteDataM, always, regardless of FIFO state.
  - Push entry {ALUResultM & 32'hFFFF_FFFC, WriteDataM} to the FIFO tail.
- misaligned: on the edge, misaligned <= MemWriteM & |ALUResultM[1:0]. The store is still performed word-aligned.
- FIFO and handshake:
  - bus_valid = (wbuf_count != 0).
  - bus_addr/bus_wdata = head entry; they must remain stable while bus_valid && !bus_ready.
  - Pop on an edge where bus_valid && bus_ready.
  - No fall-through: a push into an empty FIFO raises bus_valid on the following cycle.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Full boundary:
  - Push while full with a simultaneous pop is accepted; count stays at FIFO_DEPTH.
  - Push while full without a pop: the entry is dropped (RAM still written) and wbuf_overflow <= 1 until reset.
- Empty boundary: bus_ready while empty is ignored; there is no underflow and count stays 0.
- bus_ready may be asserted before bus_valid; transfer occurs only when both are high at the edge.

Test Plan:
- Reset then idle:
  - Assert reset asynchronously mid-cycle; all outputs listed above go to 0 immediately.
  - bus_ready=1 with no stores keeps wbuf_count=0.
- Store then load:
  - Store 0xDEADBEEF to addr 0x40. The same-cycle ReadDataM shows the old value.
  - On the next cycle, load 0x40 gives ReadDataM=0xDEADBEEF.
  - bus_valid rises one cycle after the store, with bus_addr=0x40 and bus_wdata=0xDEADBEEF.
- Back-pressure:
  - With bus_ready=0, issue 4 stores (0x0..0xC, data 1..4); wbuf_full=1 and the head stays at 0x0/1.
  - Raise bus_ready for 4 cycles; entries drain in order 1,2,3,4, then bus_valid=0.
- Overflow:
  - With a full FIFO and bus_ready=0, store 0x10/5.
  - wbuf_overflow=1 and stays high; count stays 4; RAM[0x10] reads 5.
  - Drain yields only 1..4.
- Simultaneous push/pop at full:
  - With a full FIFO, bus_ready=1 and a store 0x14/6 in the same cycle: count stays 4, no overflow.
  - 6 emerges fifth.
- Misaligned/aliasing:
  - Store 0x7 to addr 0x43: misaligned pulses for exactly 1 cycle; load 0x40 gives 0x7; bus_addr=0x40.
  - Store to addr (0x40 + 4*2^ADDR_W) overwrites word 0x40.
